uart_rx_frame_decoder: RTL and testbench
========================================

// Module: uart_rx_frame_decoder
// PURPOSE
//  - Receive side of the UART link: recovers one frame from serial RX_IN using an
//    oversampling clock. Frame = start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).
//  - Deserialises the data bits and checks parity and stop.
//  - Parity convention is the same one the TX parity generator uses.
//  - Presents a checked parallel byte with a 1-cycle valid pulse to the RX async FIFO / sys ctrl.
// PARAMETERS
//  - DATA_WIDTH  8  serial data bits per frame
//  - PRESC_W     6  width of Prescale input; oversampling ratio legal values 8, 16, 32
// PORTS
//  - CLK         in   1           RX oversampling clock (Prescale x baud)
//  - RST         in   1           asynchronous, active-low reset
//  - RX_IN       in   1           serial line, idle high, already synchronous to CLK
//  - PAR_EN      in   1           1: frame carries parity bit
//  - PAR_TYP     in   1           0: even (bit = ^data), 1: odd (bit = ~^data)
//  - Prescale    in   PRESC_W     CLK cycles per bit
//  - P_DATA      out  DATA_WIDTH  last good received word
//  - data_valid  out  1           1-cycle pulse: P_DATA updated, frame error-free
//  - par_err     out  1           1-cycle pulse: parity mismatch in current frame
//  - stp_err     out  1           1-cycle pulse: stop bit sampled 0
// BEHAVIOUR
//  - Reset: P_DATA=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, counters=0. All outputs registered.
//  - Counters:
//    - edge_cnt runs 0..Prescale-1 per bit.
//    - bit_cnt counts bits within the frame.
//    - Each bit's sample is taken at edge_cnt==Prescale/2.
//    - Decisions (state change, checks) occur at edge_cnt==Prescale-1.
//  - Config latch: PAR_EN, PAR_TYP and Prescale are latched on leaving IDLE; changes mid-frame are ignored.
//  - FSM:
//    - IDLE: RX_IN==0 -> START, edge_cnt=1.
//    - START: sampled bit 1 -> IDLE (glitch; no outputs); else -> DATA.
//    - DATA: shift sample into bit[bit_cnt] (LSB first). After bit DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
//    - PARITY: compare sample with expected (^data, or ~^data if PAR_TYP=1); mismatch sets frame error flag. -> STOP.
//    - STOP: sample 0 sets stp_err.
//  - End of STOP bit (edge_cnt==Prescale-1), next cycle:
//    - no error: P_DATA<=shift reg, data_valid=1.
//    - error: par_err and/or stp_err pulse, data_valid=0, P_DATA keeps old value.
//  - Both errors in one frame: par_err and stp_err pulse together.
//  - Back-to-back frames: at the end of STOP, if RX_IN==0, go directly to START (edge_cnt=1) with no IDLE cycle.
//  - Latency: data_valid rises 1 CLK after the last stop-bit edge.
//  - Line held low (break): start OK, data all 0, stop fails -> stp_err, then IDLE.
//  - Stays in IDLE until RX_IN returns high.
//  - Illegal Prescale (not 8/16/32): behaviour undefined; not checked in RTL.
//  - RST mid-frame: immediate return to IDLE; partial frame discarded; no pulses.
// CONFIGURATION
//  - UART_RX_MAJORITY_EN defined:
//    - Each bit is the 2-of-3 majority of samples at edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1.
//    - Resolved at Prescale/2+1. A single-cycle glitch at the centre is rejected.
//  - Undefined: single sample at edge_cnt==Prescale/2. Frame timing is identical in both builds.
// TESTING
//  - Prescale=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity 0, stop 1
//    -> data_valid 1 pulse, P_DATA=0xA5, no errors.
//  - Same frame with parity bit flipped to 1
//    -> par_err pulse; data_valid stays 0; P_DATA unchanged.
//  - Prescale=16, PAR_EN=0, send 0x3C with stop bit 0
//    -> stp_err pulse; FSM returns to IDLE once RX_IN is high.
//  - 1-cycle low glitch on idle line (Prescale=8)
//    -> START rejects it, back to IDLE, no output pulses.
//  - Two back-to-back frames 0x01 then 0xFE (PAR_TYP=1, Prescale=32)
//    -> two data_valid pulses exactly 11*32 cycles apart.
//  - Assert RST during DATA bit 4
//    -> outputs 0; a following clean 0x55 frame is received correctly.
//  - With UART_RX_MAJORITY_EN: invert RX_IN at the centre cycle of data bit 2 only
//    -> P_DATA correct, no errors.

Source files
------------

// File: rtl/uart_rx_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_frame_decoder                                      |
// | Description : UART receive frame decoder (start, data LSB first,         |
// |               optional parity, stop) on an oversampling clock.           |
// |               Define UART_RX_MAJORITY_EN for 2-of-3 bit sampling.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_rx_frame_decoder #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESC_W-1:0]    Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [PRESC_W-1:0] c_one      = PRESC_W'(1);
   localparam logic [BIT_W-1:0]   c_bit_one  = BIT_W'(1);
   localparam logic [BIT_W-1:0]   c_last_bit = BIT_W'(DATA_WIDTH - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [PRESC_W-1:0]    r_edge_cnt;
   logic [PRESC_W-1:0]    r_presc;
   logic [PRESC_W-1:0]    w_half;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_bit;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_flag;
   logic                  r_wait_high;
   logic                  w_bit_end;
   logic                  w_frame_end;
   logic                  w_start_frame;
   logic                  w_par_exp;
   logic                  w_dv_nxt;
   logic                  w_pe_nxt;
   logic                  w_se_nxt;

   assign w_half    = r_presc >> 1;
   assign w_bit_end = (r_state != S_IDLE) && (r_edge_cnt == r_presc - c_one);
   assign w_par_exp = (^r_shift) ^ r_par_typ;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic; a failed stop bit never chains into a new frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!RX_IN && !r_wait_high) w_state_nxt = S_START;
         S_START:  if (w_bit_end) w_state_nxt = r_bit ? S_IDLE : S_DATA;
         S_DATA:   if (w_bit_end && (r_bit_cnt == c_last_bit))
                      w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
         S_STOP:   if (w_bit_end) w_state_nxt = (r_bit && !RX_IN) ? S_START : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      w_frame_end   = (r_state == S_STOP) && w_bit_end;
      w_start_frame = ((r_state == S_IDLE) || w_frame_end) && (w_state_nxt == S_START);
      w_dv_nxt      = w_frame_end && r_bit && !r_par_flag;
      w_pe_nxt      = w_frame_end && r_par_flag;
      w_se_nxt      = w_frame_end && !r_bit;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt  <= '0;
         r_presc     <= '0;
         r_bit_cnt   <= '0;
         r_par_en    <= 1'b0;
         r_par_typ   <= 1'b0;
         r_shift     <= '0;
         r_par_flag  <= 1'b0;
         r_wait_high <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         data_valid <= w_dv_nxt;
         par_err    <= w_pe_nxt;
         stp_err    <= w_se_nxt;

         if (w_start_frame) begin
            r_edge_cnt <= c_one;
            r_presc    <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_bit_cnt  <= '0;
            r_par_flag <= 1'b0;
         end else if ((r_state == S_IDLE) || w_bit_end) begin
            r_edge_cnt <= '0;
         end else begin
            r_edge_cnt <= r_edge_cnt + c_one;
         end

         if ((r_state == S_DATA) && w_bit_end) begin
            r_shift   <= {r_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + c_bit_one;
         end

         if ((r_state == S_PARITY) && w_bit_end)
            r_par_flag <= r_bit ^ w_par_exp;

         if (w_dv_nxt)
            P_DATA <= r_shift;

         // After a framing error the line must go idle before a new start is accepted
         if (w_se_nxt)
            r_wait_high <= 1'b1;
         else if ((r_state == S_IDLE) && RX_IN)
            r_wait_high <= 1'b0;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic r_s0;
   logic r_s1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s0  <= 1'b1;
         r_s1  <= 1'b1;
         r_bit <= 1'b1;
      end else if (r_state != S_IDLE) begin
         if (r_edge_cnt == w_half - c_one) r_s0 <= RX_IN;
         if (r_edge_cnt == w_half)         r_s1 <= RX_IN;
         if (r_edge_cnt == w_half + c_one)
            r_bit <= (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
      end
   end
`else
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_bit <= 1'b1;
      else if ((r_state != S_IDLE) && (r_edge_cnt == w_half))
         r_bit <= RX_IN;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_decoder.sv
`default_nettype none
// Testbench for uart_rx_frame_decoder: directed cases plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_frame_decoder;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   uart_rx_frame_decoder #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
      .par_err(par_err), .stp_err(stp_err)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
   int pulse_cyc = 0, frame_c0 = 0, g_nb = 0, g_presc = 8, p1 = 0;
   logic [15:0] fb;
   logic        exp_dv, exp_pe, exp_se;
   logic [7:0]  exp_pdata = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic rx);
      RX_IN = rx;
      @(posedge CLK); #1;
      cyc++;
      if (data_valid === 1'b1) begin dv_cnt++; pulse_cyc = cyc; end
      if (par_err === 1'b1)    begin pe_cnt++; pulse_cyc = cyc; end
      if (stp_err === 1'b1)    begin se_cnt++; pulse_cyc = cyc; end
   endtask

   task automatic clr();
      dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
   endtask

   // Builds the serial frame and predicts the receiver's verdict from the frame contents.
   // max_ticks = 0 sends the whole frame; glitch_at inverts one line cycle (-1 = none).
   task automatic frame(input logic [7:0] data, input bit pen, input bit ptyp, input int presc,
                        input bit pflip, input bit stop_v, input int glitch_at, input int max_ticks);
      logic p_good, v;
      int   n, t;
      p_good = ptyp ? ~^data : ^data;
      n = 0;
      fb = '0;
      fb[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin fb[n] = data[i]; n++; end
      if (pen) begin fb[n] = p_good ^ pflip; n++; end
      fb[n] = stop_v; n++;
      g_nb = n;
      g_presc = presc;
      exp_pe = pen && (fb[9] != p_good);
      exp_se = !stop_v;
      exp_dv = !exp_pe && !exp_se;
      if (exp_dv) exp_pdata = data;

      PAR_EN = pen; PAR_TYP = ptyp; Prescale = 6'(presc);
      t = 0;
      for (int b = 0; b < n; b++) begin
         for (int k = 0; k < presc; k++) begin
            if (max_ticks != 0 && t >= max_ticks) return;
            v = fb[b];
            if (t == glitch_at) v = ~v;
            tick(v);
            if (t == 0) begin
               frame_c0 = cyc;
               PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); Prescale = 6'($urandom);
            end
            t++;
         end
      end
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_dv"},  dv_cnt, {31'd0, exp_dv});
      chk({tag, "_pe"},  pe_cnt, {31'd0, exp_pe});
      chk({tag, "_se"},  se_cnt, {31'd0, exp_se});
      chk({tag, "_pd"},  {24'd0, P_DATA}, {24'd0, exp_pdata});
      chk({tag, "_lat"}, pulse_cyc, frame_c0 + g_nb * g_presc - 1);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   initial begin
      int presc_tab[3];
      presc_tab[0] = 8; presc_tab[1] = 16; presc_tab[2] = 32;

      // Reset state
      tick(1'b1); tick(1'b1);
      chk("rst_pdata", {24'd0, P_DATA}, 32'd0);
      chk("rst_dv", {31'd0, data_valid}, 32'd0);
      chk("rst_pe", {31'd0, par_err}, 32'd0);
      chk("rst_se", {31'd0, stp_err}, 32'd0);
      RST = 1'b1;
      gap(4); clr();

      // Good frame with even parity
      frame(8'hA5, 1, 0, 8, 0, 1, -1, 0);
      check_frame("a5_ok");
      clr(); gap(3);

      // Same frame, parity flipped
      frame(8'hA5, 1, 0, 8, 1, 1, -1, 0);
      check_frame("a5_par");
      clr(); gap(3);

      // Stop bit 0, no parity, Prescale 16
      frame(8'h3C, 0, 0, 16, 0, 0, -1, 0);
      check_frame("3c_stp");
      clr(); gap(3);

      // One-cycle glitch on idle line
      PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
      tick(1'b0); gap(24);
      chk("glitch_dv", dv_cnt, 0);
      chk("glitch_pe", pe_cnt, 0);
      chk("glitch_se", se_cnt, 0);
      clr();

      // Back-to-back frames, odd parity, Prescale 32
      frame(8'h01, 1, 1, 32, 0, 1, -1, 0);
      check_frame("b2b_1");
      p1 = pulse_cyc;
      clr();
      frame(8'hFE, 1, 1, 32, 0, 1, -1, 0);
      check_frame("b2b_2");
      chk("b2b_gap", pulse_cyc - p1, 11 * 32);
      clr(); gap(3);

      // Reset in the middle of data bit 4
      frame(8'hC3, 0, 0, 8, 0, 1, -1, 5 * 8 + 4);
      #2 RST = 1'b0;
      #1;
      exp_pdata = 8'h00;
      chk("mrst_pdata", {24'd0, P_DATA}, 32'd0);
      chk("mrst_dv", {31'd0, data_valid}, 32'd0);
      chk("mrst_pe", {31'd0, par_err}, 32'd0);
      chk("mrst_se", {31'd0, stp_err}, 32'd0);
      tick(1'b1); tick(1'b1);
      RST = 1'b1;
      clr(); gap(3);
      frame(8'h55, 1, 0, 8, 0, 1, -1, 0);
      check_frame("post_rst_55");
      clr(); gap(3);

      // Break: line held low
      frame(8'h00, 0, 0, 8, 0, 0, -1, 0);
      check_frame("break");
      clr();
      for (int i = 0; i < 40; i++) tick(1'b0);
      chk("break_hold_dv", dv_cnt, 0);
      chk("break_hold_se", se_cnt, 0);
      chk("break_hold_pe", pe_cnt, 0);
      clr(); gap(3);

`ifdef UART_RX_MAJORITY_EN
      // Centre-cycle glitch on data bit 2 is outvoted
      frame(8'h5A, 1, 0, 16, 0, 1, 3 * 16 + 8, 0);
      check_frame("maj_glitch");
      clr(); gap(3);
`endif

      // Randomized frames
      for (int f = 0; f < 16; f++) begin
         logic [7:0] d;
         bit pen, ptyp, pflip, stop_v;
         int presc;
         d      = 8'($urandom);
         pen    = 1'($urandom);
         ptyp   = 1'($urandom);
         pflip  = ($urandom_range(0, 3) == 0);
         stop_v = ($urandom_range(0, 3) != 0);
         presc  = presc_tab[$urandom_range(0, 2)];
         frame(d, pen, ptyp, presc, pflip, stop_v, -1, 0);
         check_frame($sformatf("rnd%0d", f));
         clr();
         gap($urandom_range(1, 6));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
